// File: rtl/wb_mem_arbiter.sv
// Two-master Wishbone pipelined arbiter sharing one memory port.
// Grants whole cyc tenures round-robin; a watchdog aborts tenures stalled on a missing ack.
module wb_mem_arbiter #(
   parameter int AWIDTH  = 32,
   parameter int DWIDTH  = 32,
   parameter int TIMEOUT = 256
) (
   input  logic              clk_i,
   input  logic              rst_i,
   input  logic              m0_cyc_i,
   input  logic              m0_stb_i,
   input  logic              m0_we_i,
   input  logic [AWIDTH-1:0] m0_adr_i,
   input  logic [3:0]        m0_sel_i,
   input  logic [DWIDTH-1:0] m0_dat_i,
   output logic [DWIDTH-1:0] m0_dat_o,
   output logic              m0_ack_o,
   output logic              m0_stall_o,
   output logic              m0_err_o,
   input  logic              m1_cyc_i,
   input  logic              m1_stb_i,
   input  logic              m1_we_i,
   input  logic [AWIDTH-1:0] m1_adr_i,
   input  logic [3:0]        m1_sel_i,
   input  logic [DWIDTH-1:0] m1_dat_i,
   output logic [DWIDTH-1:0] m1_dat_o,
   output logic              m1_ack_o,
   output logic              m1_stall_o,
   output logic              m1_err_o,
   output logic              s_cyc_o,
   output logic              s_stb_o,
   output logic              s_we_o,
   output logic [AWIDTH-1:0] s_adr_o,
   output logic [3:0]        s_sel_o,
   output logic [DWIDTH-1:0] s_dat_o,
   input  logic [DWIDTH-1:0] s_dat_i,
   input  logic              s_ack_i,
   input  logic              s_stall_i,
   output logic [1:0]        grant_o,
   output logic [15:0]       timeouts_o
);

   typedef enum logic [1:0] {S_IDLE, S_OWN0, S_OWN1, S_ABORT} state_t;

   localparam logic [15:0] WDOG_LAST = 16'(TIMEOUT - 1);

   state_t      state, state_d, arb_next;
   logic        last, last_d;
   logic [15:0] wdog, wdog_d, timeouts_d;
   logic [1:0]  err_q, err_d;
   logic        own_cyc;

   // In owning and abort states, last always names the current (or aborted) master.
   assign own_cyc = last ? m1_cyc_i : m0_cyc_i;

   always_comb begin
      arb_next = S_IDLE;
      if (m0_cyc_i && m1_cyc_i) arb_next = last ? S_OWN0 : S_OWN1;
      else if (m0_cyc_i)        arb_next = S_OWN0;
      else if (m1_cyc_i)        arb_next = S_OWN1;
   end

   // NOTE: every signal assigned in always_comb gets a default first, so no latch is inferred.
   always_comb begin
      state_d    = state;
      wdog_d     = '0;
      err_d      = '0;
      timeouts_d = timeouts_o;
      case (state)
         S_IDLE: state_d = arb_next;
         S_OWN0, S_OWN1: begin
            if (!own_cyc) begin
               state_d = arb_next;
            end else if (s_ack_i) begin
               wdog_d = '0;
            end else if (wdog == WDOG_LAST) begin
               state_d      = S_ABORT;
               err_d[last]  = 1'b1;
               if (timeouts_o != 16'hFFFF) timeouts_d = timeouts_o + 16'd1;
            end else begin
               wdog_d = wdog + 16'd1;
            end
         end
         S_ABORT: if (!own_cyc) state_d = arb_next;
         default: state_d = S_IDLE;
      endcase
      last_d = last;
      if (state_d == S_OWN0)      last_d = 1'b0;
      else if (state_d == S_OWN1) last_d = 1'b1;
   end

   // NOTE: sequential state uses non-blocking assignments only.
   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         state      <= S_IDLE;
         last       <= 1'b1;
         wdog       <= '0;
         err_q      <= '0;
         timeouts_o <= '0;
      end else begin
         state      <= state_d;
         last       <= last_d;
         wdog       <= wdog_d;
         err_q      <= err_d;
         timeouts_o <= timeouts_d;
      end
   end

   always_comb begin
      s_cyc_o    = 1'b0;
      s_stb_o    = 1'b0;
      s_we_o     = 1'b0;
      s_adr_o    = '0;
      s_sel_o    = '0;
      s_dat_o    = '0;
      m0_ack_o   = 1'b0;
      m1_ack_o   = 1'b0;
      m0_stall_o = 1'b1;
      m1_stall_o = 1'b1;
      grant_o    = 2'b00;
      case (state)
         S_OWN0: begin
            s_cyc_o    = m0_cyc_i;
            s_stb_o    = m0_stb_i;
            s_we_o     = m0_we_i;
            s_adr_o    = m0_adr_i;
            s_sel_o    = m0_sel_i;
            s_dat_o    = m0_dat_i;
            m0_ack_o   = s_ack_i;
            m0_stall_o = s_stall_i;
            grant_o    = 2'b01;
         end
         S_OWN1: begin
            s_cyc_o    = m1_cyc_i;
            s_stb_o    = m1_stb_i;
            s_we_o     = m1_we_i;
            s_adr_o    = m1_adr_i;
            s_sel_o    = m1_sel_i;
            s_dat_o    = m1_dat_i;
            m1_ack_o   = s_ack_i;
            m1_stall_o = s_stall_i;
            grant_o    = 2'b10;
         end
         default: ;
      endcase
   end

   // Read data is broadcast; it is forced low only so every output is quiet in reset.
   assign m0_dat_o = rst_i ? '0 : s_dat_i;
   assign m1_dat_o = rst_i ? '0 : s_dat_i;
   assign m0_err_o = err_q[0];
   assign m1_err_o = err_q[1];

endmodule

// File: tb/tb_wb_mem_arbiter.sv
// Randomized self-checking bench for wb_mem_arbiter against a tenure-level reference model.
module tb_wb_mem_arbiter;
   localparam int AW = 32;
   localparam int DW = 32;
   localparam int TO = 8;

   logic          clk_i = 1'b0;
   logic          rst_i;
   logic          m0_cyc_i, m0_stb_i, m0_we_i, m1_cyc_i, m1_stb_i, m1_we_i;
   logic [AW-1:0] m0_adr_i, m1_adr_i, s_adr_o;
   logic [3:0]    m0_sel_i, m1_sel_i, s_sel_o;
   logic [DW-1:0] m0_dat_i, m1_dat_i, m0_dat_o, m1_dat_o, s_dat_o, s_dat_i;
   logic          m0_ack_o, m0_stall_o, m0_err_o, m1_ack_o, m1_stall_o, m1_err_o;
   logic          s_cyc_o, s_stb_o, s_we_o, s_ack_i, s_stall_i;
   logic [1:0]    grant_o;
   logic [15:0]   timeouts_o;

   always #5 clk_i = ~clk_i;

   wb_mem_arbiter #(.AWIDTH(AW), .DWIDTH(DW), .TIMEOUT(TO)) dut (
      .clk_i(clk_i), .rst_i(rst_i),
      .m0_cyc_i(m0_cyc_i), .m0_stb_i(m0_stb_i), .m0_we_i(m0_we_i), .m0_adr_i(m0_adr_i),
      .m0_sel_i(m0_sel_i), .m0_dat_i(m0_dat_i), .m0_dat_o(m0_dat_o), .m0_ack_o(m0_ack_o),
      .m0_stall_o(m0_stall_o), .m0_err_o(m0_err_o),
      .m1_cyc_i(m1_cyc_i), .m1_stb_i(m1_stb_i), .m1_we_i(m1_we_i), .m1_adr_i(m1_adr_i),
      .m1_sel_i(m1_sel_i), .m1_dat_i(m1_dat_i), .m1_dat_o(m1_dat_o), .m1_ack_o(m1_ack_o),
      .m1_stall_o(m1_stall_o), .m1_err_o(m1_err_o),
      .s_cyc_o(s_cyc_o), .s_stb_o(s_stb_o), .s_we_o(s_we_o), .s_adr_o(s_adr_o),
      .s_sel_o(s_sel_o), .s_dat_o(s_dat_o), .s_dat_i(s_dat_i), .s_ack_i(s_ack_i),
      .s_stall_i(s_stall_i), .grant_o(grant_o), .timeouts_o(timeouts_o)
   );

   int n_checks = 0;
   int n_fail   = 0;

   task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
      end
   endtask

   // Stimulus for the coming cycle
   logic [1:0]    st_cyc, st_stb, st_we;
   logic [AW-1:0] st_adr [2];
   logic [3:0]    st_sel [2];
   logic [DW-1:0] st_dat [2];
   logic          st_ack, st_stall;
   logic [DW-1:0] st_sdat;
   int            hold [2];
   int            quiet;

   // Reference model: who owns the port, whether that tenure was aborted, and ack-less cycles
   int       md_owner;
   bit       md_abort;
   int       md_last;
   int       md_wait;
   int       md_tmo;
   bit [1:0] md_err;

   task automatic model_reset();
      md_owner = -1;
      md_abort = 1'b0;
      md_last  = 1;
      md_wait  = 0;
      md_tmo   = 0;
      md_err   = '0;
   endtask

   task automatic model_advance();
      bit [1:0] nerr = '0;
      int pick = -1;
      if (md_owner >= 0 && !md_abort && st_cyc[md_owner]) begin
         if (st_ack) md_wait = 0;
         else if (md_wait == TO - 1) begin
            md_abort = 1'b1;
            nerr[md_owner] = 1'b1;
            if (md_tmo < 65535) md_tmo++;
         end else md_wait++;
      end else if (!(md_abort && st_cyc[md_owner])) begin
         // Idle, a release, or an abort whose master has let go: arbitrate afresh.
         md_abort = 1'b0;
         if (st_cyc == 2'b11) pick = 1 - md_last;
         else if (st_cyc[0])  pick = 0;
         else if (st_cyc[1])  pick = 1;
         md_owner = pick;
         if (pick >= 0) begin
            md_last = pick;
            md_wait = 0;
         end
      end
      md_err = nerr;
   endtask

   task automatic check_outputs();
      logic [1:0]    e_grant = '0;
      logic          e_cyc = 1'b0, e_stb = 1'b0, e_we = 1'b0;
      logic [AW-1:0] e_adr = '0;
      logic [3:0]    e_sel = '0;
      logic [DW-1:0] e_dat = '0;
      logic [1:0]    e_ack = '0;
      logic [1:0]    e_stall = 2'b11;
      if (md_owner >= 0 && !md_abort) begin
         e_grant[md_owner] = 1'b1;
         e_cyc = st_cyc[md_owner];
         e_stb = st_stb[md_owner];
         e_we  = st_we[md_owner];
         e_adr = st_adr[md_owner];
         e_sel = st_sel[md_owner];
         e_dat = st_dat[md_owner];
         e_ack[md_owner]   = st_ack;
         e_stall[md_owner] = st_stall;
      end
      check("grant", grant_o, e_grant);
      check("s_cyc", s_cyc_o, e_cyc);
      check("s_stb", s_stb_o, e_stb);
      check("s_we", s_we_o, e_we);
      check("s_adr", s_adr_o, e_adr);
      check("s_sel", s_sel_o, e_sel);
      check("s_dat", s_dat_o, e_dat);
      check("m_ack", {m1_ack_o, m0_ack_o}, e_ack);
      check("m_stall", {m1_stall_o, m0_stall_o}, e_stall);
      check("m0_dat", m0_dat_o, st_sdat);
      check("m1_dat", m1_dat_o, st_sdat);
      check("m_err", {m1_err_o, m0_err_o}, md_err);
      check("timeouts", timeouts_o, md_tmo);
   endtask

   task automatic run_cycle();
      @(negedge clk_i);
      rst_i     = 1'b0;
      m0_cyc_i  = st_cyc[0]; m0_stb_i = st_stb[0]; m0_we_i = st_we[0];
      m0_adr_i  = st_adr[0]; m0_sel_i = st_sel[0]; m0_dat_i = st_dat[0];
      m1_cyc_i  = st_cyc[1]; m1_stb_i = st_stb[1]; m1_we_i = st_we[1];
      m1_adr_i  = st_adr[1]; m1_sel_i = st_sel[1]; m1_dat_i = st_dat[1];
      s_ack_i   = st_ack;    s_stall_i = st_stall; s_dat_i = st_sdat;
      #1;
      check_outputs();
      model_advance();
   endtask

   task automatic rand_payload();
      for (int i = 0; i < 2; i++) begin
         st_stb[i] = st_cyc[i] & 1'($urandom_range(1));
         st_we[i]  = 1'($urandom_range(1));
         st_adr[i] = AW'($urandom);
         st_sel[i] = 4'($urandom);
         st_dat[i] = DW'($urandom);
      end
      st_stall = 1'($urandom_range(1));
      st_sdat  = DW'($urandom);
   endtask

   task automatic dir_cycle(input logic [1:0] cyc, input logic ack);
      st_cyc = cyc;
      rand_payload();
      st_ack = ack;
      run_cycle();
   endtask

   task automatic rand_cycle();
      for (int i = 0; i < 2; i++) begin
         if (hold[i] > 0) begin
            st_cyc[i] = 1'b1;
            hold[i]--;
         end else begin
            st_cyc[i] = 1'b0;
            if ($urandom_range(3) == 0) hold[i] = int'($urandom_range(24, 1));
         end
      end
      rand_payload();
      if (quiet > 0) begin
         quiet--;
         st_ack = 1'b0;
      end else begin
         st_ack = 1'($urandom_range(1));
         if ($urandom_range(15) == 0) quiet = int'($urandom_range(14, 4));
      end
      run_cycle();
   endtask

   task automatic check_reset_outputs(input string tag);
      check({tag, "_s_cyc"}, s_cyc_o, 1'b0);
      check({tag, "_s_stb"}, s_stb_o, 1'b0);
      check({tag, "_grant"}, grant_o, 2'b00);
      check({tag, "_tmo"}, timeouts_o, 16'd0);
      check({tag, "_stall"}, {m1_stall_o, m0_stall_o}, 2'b11);
      check({tag, "_ack"}, {m1_ack_o, m0_ack_o}, 2'b00);
      check({tag, "_err"}, {m1_err_o, m0_err_o}, 2'b00);
      check({tag, "_dat"}, {m1_dat_o, m0_dat_o}, '0);
   endtask

   task automatic clear_stim();
      st_cyc = '0; st_stb = '0; st_we = '0; st_ack = 1'b0; st_stall = 1'b0; st_sdat = '0;
      for (int i = 0; i < 2; i++) begin
         st_adr[i] = '0; st_sel[i] = '0; st_dat[i] = '0; hold[i] = 0;
      end
      quiet = 0;
   endtask

   initial begin
      clear_stim();
      rst_i = 1'b1;
      m0_cyc_i = 0; m0_stb_i = 0; m0_we_i = 0; m0_adr_i = '0; m0_sel_i = '0; m0_dat_i = '0;
      m1_cyc_i = 0; m1_stb_i = 0; m1_we_i = 0; m1_adr_i = '0; m1_sel_i = '0; m1_dat_i = '0;
      s_ack_i = 0; s_stall_i = 0; s_dat_i = 32'hDEAD_BEEF;
      model_reset();
      #1;
      check_reset_outputs("rst0");
      @(posedge clk_i);
      run_cycle();

      // Tie from reset goes to m0, hand-off to m1 without a gap, then alternation back to m0.
      repeat (3) dir_cycle(2'b11, 1'b1);
      repeat (3) dir_cycle(2'b10, 1'b1);
      repeat (3) dir_cycle(2'b11, 1'b1);
      repeat (2) dir_cycle(2'b01, 1'b0);
      repeat (3) dir_cycle(2'b11, 1'b1);
      repeat (2) dir_cycle(2'b00, 1'b0);

      // m0 alone with a silent slave: watchdog fires, then m1 takes over once m0 lets go.
      repeat (12) dir_cycle(2'b01, 1'b0);
      repeat (2) dir_cycle(2'b11, 1'b0);
      repeat (3) dir_cycle(2'b10, 1'b1);
      repeat (2) dir_cycle(2'b00, 1'b0);

      // Ack on the last watchdog cycle, then a release landing on the would-be timeout.
      for (int k = 0; k < 17; k++) dir_cycle((k < 16) ? 2'b01 : 2'b00, (k == 8));
      repeat (2) dir_cycle(2'b00, 1'b0);

      repeat (1500) rand_cycle();

      // Asynchronous reset mid-tenure.
      st_cyc = 2'b01;
      repeat (4) dir_cycle(2'b01, 1'b0);
      @(posedge clk_i);
      #3;
      rst_i = 1'b1;
      #1;
      check_reset_outputs("rst1");
      model_reset();
      clear_stim();
      run_cycle();
      repeat (3) dir_cycle(2'b11, 1'b0);

      repeat (1500) rand_cycle();

      $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
      $finish;
   end
endmodule

// File: doc/wb_mem_arbiter.md
Name: wb_mem_arbiter

Overview:
- Two-master Wishbone pipelined arbiter that shares one downstream memory port, for example between an instruction cache and a data cache feeding SDRAM.
- Grants the bus for a whole cyc tenure, so a cache line fill or flush is never interleaved with the other master's traffic.
- Round-robin fairness between the two masters.
- A watchdog terminates a tenure stalled on a missing ack.

Parameters:
- AWIDTH, 32, address width on all ports.
- DWIDTH, 32, data width.
- TIMEOUT, 256, cycles without ack before the watchdog fires; legal range 2..65535.

Ports:
- clk_i  in  1  clock.
- rst_i  in  1  reset; asynchronous, active-high.
- mN_cyc_i  in  1  master N cycle (N = 0, 1).
- mN_stb_i  in  1  master N strobe.
- mN_we_i  in  1  master N write enable.
- mN_adr_i  in  AWIDTH  master N address.
- mN_sel_i  in  4  master N byte selects.
- mN_dat_i  in  DWIDTH  master N write data.
- mN_dat_o  out  DWIDTH  read data to master N.
- mN_ack_o  out  1  ack to master N.
- mN_stall_o  out  1  stall to master N.
- mN_err_o  out  1  watchdog error to master N.
- s_cyc_o, s_stb_o, s_we_o  out  1  slave control.
- s_adr_o  out  AWIDTH  slave address.
- s_sel_o  out  4  slave byte selects.
- s_dat_o  out  DWIDTH  slave write data.
- s_dat_i  in  DWIDTH  slave read data.
- s_ack_i  in  1  slave ack.
- s_stall_i  in  1  slave stall.
- grant_o  out  2  one-hot current owner; 00 means idle.
- timeouts_o  out  16  saturating count of watchdog events.

Behaviour:
- State machine states: S_IDLE, S_OWN0, S_OWN1, S_ABORT.
  - Registers: state, last (last master served, 1 bit), wdog (16 bits), timeouts_o.
  - Reset values: state S_IDLE, last 1 (so m0 wins the first tie), wdog 0, timeouts_o 0.
- Combinational outputs:
  - s_* mirrors the owner's inputs, gated: s_cyc_o = owner cyc, s_stb_o = owner stb.
  - Owner sees s_dat_i, s_ack_i and s_stall_i.
  - Non-owner sees ack 0, stall 1, dat_o equal to s_dat_i (don't-care).
  - In S_IDLE and S_ABORT: s_cyc_o = s_stb_o = 0, both masters stall = 1.
  - All outputs are 0 during reset, except mN_stall_o, which is 1.
- S_IDLE:
  - If exactly one mN_cyc_i is high, go to S_OWNN.
  - If both are high, go to S_OWN(~last).
  - Grant latency is 1 cycle from cyc; no strobe is accepted in the request cycle.
- S_OWNN:
  - Set last = N on entry.
  - On a cycle with mN_cyc_i = 0 (release): if the other master's cyc is high, go directly to S_OWN(other) (no idle bubble); else go to S_IDLE.
  - Owner stb/ack/stall pass through combinationally.
  - The arbiter does not track outstanding transactions; masters must hold cyc until their acks return.
- Watchdog:
  - In S_OWNN, wdog clears on entry and on any cycle with s_ack_i = 1.
  - Otherwise wdog increments each cycle while owner cyc = 1.
  - When wdog == TIMEOUT-1 and no ack that cycle: go to S_ABORT and pulse mN_err_o for exactly one cycle (the transition cycle, registered).
  - timeouts_o increments and saturates at 0xFFFF.
- S_ABORT:
  - s_cyc_o held 0.
  - Stay until the aborted master's cyc_i = 0, then apply the S_IDLE rules, with last = aborted master.
- Simultaneous events:
  - A release and a watchdog fire in the same cycle count as a release; no err, no count.
  - An ack arriving on the same cycle the watchdog would fire wins: wdog clears.
- Reset mid-tenure: immediate return to S_IDLE, s_cyc_o drops asynchronously, no err pulse.

Test Plan:
- m0 alone: raise cyc, 4 strobes, slave acks each 2 cycles later -> grant_o=01 one cycle after cyc; 4 acks on m0_ack_o; m1_stall_o=1 throughout; back to grant_o=00 after cyc drops.
- Both cyc rise same cycle from reset -> m0 granted first; on m0 release the next cycle shows grant_o=10 with no 00 gap; repeat with both requesting -> m0 again (alternation).
- m1 holds a 4-beat burst while m0 requests mid-burst -> m0 sees stall=1, ack=0 until m1 drops cyc; s_adr_o shows only m1 addresses during the burst.
- TIMEOUT=8, slave never acks -> m0_err_o high exactly once, 8 cycles after grant; s_cyc_o=0 next cycle; timeouts_o=1; m1 granted after m0 drops cyc.
- Ack on the cycle wdog == TIMEOUT-1 -> no err, wdog restarts; release coinciding with timeout -> no err, timeouts_o unchanged.
- Assert rst_i mid-burst -> s_cyc_o=0, grant_o=00 asynchronously, timeouts_o=0; first grant after reset goes to m0 on a tie.
